// File: rtl/audio_input_controller_pkg.sv
// Shared types and constants for the audio capture path: the stereo sample
// layout, the register map of the CPU port and the control/status bit layout.
package audio_pkg;

    // One stereo sample exactly as it is stored in the FIFO and returned by a pop.
    typedef struct packed {
        logic [15:0] left;
        logic [15:0] right;
    } sample_t;

    // Register indices on the 4-bit CPU address bus.
    localparam logic [3:0] AUDIO_REG_DATA   = 4'd0;
    localparam logic [3:0] AUDIO_REG_QUEUED = 4'd1;
    localparam logic [3:0] AUDIO_REG_RATE   = 4'd2;
    localparam logic [3:0] AUDIO_REG_CTRL   = 4'd3;

    // Bit positions inside the control/status register.
    localparam int CTRL_ENABLE_BIT   = 0;
    localparam int CTRL_OVERRUN_BIT  = 1;
    localparam int CTRL_UNDERRUN_BIT = 2;
    localparam int CTRL_FLUSH_BIT    = 3;

    // Divider for 22050 Hz * 256 from a 100 MHz system clock.
    localparam logic [31:0] AUDIO_DEFAULT_RATE = 32'd17;

    // Status word layout; the flush position always reads back as zero.
    function automatic logic [31:0] ctrl_status(input logic enable,
                                                input logic overrun,
                                                input logic underrun);
        return {28'd0, 1'b0, underrun, overrun, enable};
    endfunction

endpackage

// File: rtl/audio_input_controller_capture_fifo.sv
// First-word-fall-through sample FIFO for the capture path. Owns the rules for
// simultaneous push/pop: a pop is only honoured when data is present, a push
// into a full FIFO is only honoured when a pop frees a slot on the same edge,
// and a flush discards both pointers and any push on the same edge.
module audio_capture_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  sample_t                  wdata,
    output sample_t                  rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_COUNT = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_COUNT  = CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR    = PTR_W'(1);

    sample_t            mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               pop_ok_s;
    logic               push_ok_s;

    // Decide which of the requested operations actually take effect this edge.
    always_comb begin
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        if (flush) begin
            pop_ok_s  = 1'b0;
            push_ok_s = 1'b0;
        end else begin
            pop_ok_s  = pop && (count_r != ZERO_COUNT);
            push_ok_s = push && ((count_r != FULL_COUNT) || pop_ok_s);
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= ZERO_COUNT;
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= ZERO_COUNT;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_PTR;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_PTR;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + ONE_COUNT;
                2'b01:   count_r <= count_r - ONE_COUNT;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sample storage; cleared on reset so the head never shows stale data.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{left: 16'd0, right: 16'd0};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign empty = (count_r == ZERO_COUNT);
    assign full  = (count_r == FULL_COUNT);
    assign count = count_r;

endmodule

// File: rtl/audio_input_controller.sv
// Audio capture controller: detects each level change of the input sample
// strobe, queues the stereo sample in a small FIFO and exposes the FIFO, the
// sample-rate divider and the enable/overrun/underrun flags through a simple
// request/ready register port (one side effect per request).
module audio_input_controller
    import audio_pkg::*;
#(
    parameter int BUFFER_SIZE = 4
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic        i_rw,
    input  logic [3:0]  i_address,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    input  logic        i_input_sample_clock,
    input  logic [15:0] i_input_sample_left,
    input  logic [15:0] i_input_sample_right,
    output logic [31:0] o_input_sample_rate,
    output logic        o_input_enable
);

    localparam int CNT_W = $clog2(BUFFER_SIZE) + 1;

    logic               last_sample_clock_r;
    logic               enable_r;
    logic               overrun_r;
    logic               underrun_r;
    logic [31:0]        rate_r;
    logic [31:0]        rdata_r;
    logic               ready_r;

    sample_t            capture_s;
    sample_t            head_s;
    logic               fifo_empty_s;
    logic               fifo_full_s;
    logic [CNT_W-1:0]   fifo_count_s;

    logic               toggle_s;
    logic               push_s;
    logic               access_s;
    logic               pop_s;
    logic               pop_accept_s;
    logic               ctrl_wr_s;
    logic               rate_wr_s;
    logic               flush_s;
    logic               overrun_set_s;
    logic               overrun_clr_s;
    logic               underrun_set_s;
    logic               underrun_clr_s;
    logic [31:0]        read_mux_s;

    // Decode strobe toggles and CPU accesses into per-cycle events.
    always_comb begin
        capture_s.left  = i_input_sample_left;
        capture_s.right = i_input_sample_right;
        toggle_s        = (i_input_sample_clock != last_sample_clock_r);
        push_s          = toggle_s && enable_r;
        // A request is acted on only in the cycle before o_ready rises.
        access_s        = i_request && !ready_r;
        pop_s           = access_s && !i_rw && (i_address == AUDIO_REG_DATA);
        ctrl_wr_s       = access_s && i_rw && (i_address == AUDIO_REG_CTRL);
        rate_wr_s       = access_s && i_rw && (i_address == AUDIO_REG_RATE);
        flush_s         = ctrl_wr_s && i_wdata[CTRL_FLUSH_BIT];
        pop_accept_s    = pop_s && !fifo_empty_s;
        // A sample lost to a flush is intentional and not an overrun.
        overrun_set_s   = push_s && fifo_full_s && !pop_accept_s && !flush_s;
        overrun_clr_s   = ctrl_wr_s && i_wdata[CTRL_OVERRUN_BIT];
        underrun_set_s  = pop_s && fifo_empty_s;
        underrun_clr_s  = ctrl_wr_s && i_wdata[CTRL_UNDERRUN_BIT];
    end

    // Register read multiplexer; unmapped addresses read as zero.
    always_comb begin
        read_mux_s = 32'd0;
        case (i_address)
            AUDIO_REG_DATA: begin
                if (fifo_empty_s) begin
                    read_mux_s = 32'd0;
                end else begin
                    read_mux_s = head_s;
                end
            end
            AUDIO_REG_QUEUED: read_mux_s = 32'(fifo_count_s);
            AUDIO_REG_RATE:   read_mux_s = rate_r;
            AUDIO_REG_CTRL:   read_mux_s = ctrl_status(enable_r, overrun_r, underrun_r);
            default:          read_mux_s = 32'd0;
        endcase
    end

    // CPU handshake: ready follows the request one cycle later, data latched on access.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            ready_r <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            ready_r <= i_request;
            if (access_s && !i_rw) begin
                rdata_r <= read_mux_s;
            end else if (access_s) begin
                rdata_r <= 32'd0;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // Capture configuration and strobe history.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            last_sample_clock_r <= 1'b0;
            enable_r            <= 1'b0;
            rate_r              <= AUDIO_DEFAULT_RATE;
        end else begin
            last_sample_clock_r <= i_input_sample_clock;
            if (ctrl_wr_s) begin
                enable_r <= i_wdata[CTRL_ENABLE_BIT];
            end else begin
                enable_r <= enable_r;
            end
            if (rate_wr_s) begin
                rate_r <= i_wdata;
            end else begin
                rate_r <= rate_r;
            end
        end
    end

    // Sticky error flags; a set on the same edge as a clear wins.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            overrun_r  <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end else if (overrun_clr_s) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
            if (underrun_set_s) begin
                underrun_r <= 1'b1;
            end else if (underrun_clr_s) begin
                underrun_r <= 1'b0;
            end else begin
                underrun_r <= underrun_r;
            end
        end
    end

    audio_capture_fifo #(
        .DEPTH (BUFFER_SIZE)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .push    (push_s),
        .pop     (pop_s),
        .flush   (flush_s),
        .wdata   (capture_s),
        .rdata   (head_s),
        .empty   (fifo_empty_s),
        .full    (fifo_full_s),
        .count   (fifo_count_s)
    );

    assign o_ready             = ready_r;
    assign o_rdata             = rdata_r;
    assign o_input_sample_rate = rate_r;
    assign o_input_enable      = enable_r;

endmodule
